// File: rtl/wb_rob_param.sv
// Parameterized reorder buffer: in-order allocation, out-of-order multi-port completion,
// in-order retire to the register file, precise exception flush, and a two-source result bypass.
module wb_rob_param #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_PORTS   = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEST_W      = 5,
    parameter int unsigned PC_W        = 32,
    localparam int unsigned IDX_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid,
    input  logic [DEST_W-1:0]             alloc_dest,
    input  logic [PC_W-1:0]               alloc_pc,
    output logic                          alloc_ready,
    output logic [IDX_W-1:0]              alloc_id,
    input  logic [NUM_PORTS-1:0]          cmpl_valid,
    input  logic [NUM_PORTS*IDX_W-1:0]    cmpl_id,
    input  logic [NUM_PORTS*DATA_W-1:0]   cmpl_data,
    input  logic [NUM_PORTS-1:0]          cmpl_xcpt,
    output logic                          rf_we,
    output logic [DEST_W-1:0]             rf_dest,
    output logic [DATA_W-1:0]             rf_data,
    output logic [IDX_W-1:0]              rf_id,
    output logic                          xcpt_valid,
    output logic [PC_W-1:0]               xcpt_pc,
    output logic [IDX_W-1:0]              xcpt_id,
    output logic                          flush,
    input  logic [2*IDX_W-1:0]            byp_id,
    output logic [1:0]                    byp_hit,
    output logic [2*DATA_W-1:0]           byp_data,
    output logic [IDX_W:0]                count,
    output logic [IDX_W-1:0]              oldest_id
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d, done_q, done_d, xcpt_q, xcpt_d;
    logic [DEST_W-1:0]      dest_q [NUM_ENTRIES];
    logic [DEST_W-1:0]      dest_d [NUM_ENTRIES];
    logic [PC_W-1:0]        pc_q   [NUM_ENTRIES];
    logic [PC_W-1:0]        pc_d   [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_q [NUM_ENTRIES];
    logic [DATA_W-1:0]      data_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   rf_we_q, rf_we_d, xcpt_valid_q, xcpt_valid_d, flush_q, flush_d;
    logic [DEST_W-1:0]      rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0]      rf_data_q, rf_data_d;
    logic [IDX_W-1:0]       rf_id_q, rf_id_d, xcpt_id_q, xcpt_id_d;
    logic [PC_W-1:0]        xcpt_pc_q, xcpt_pc_d;

    logic                   head_done, retire, flush_pending, alloc_fire;
    logic [IDX_W-1:0]       cid, bid;

    // Head entry decides this cycle's retire or exception; an exception blocks new work.
    assign head_done     = valid_q[head_q] & done_q[head_q];
    assign retire        = head_done & ~xcpt_q[head_q];
    assign flush_pending = head_done & xcpt_q[head_q];
    assign alloc_ready   = (count_q < CNT_W'(NUM_ENTRIES)) & ~flush_pending;
    assign alloc_fire    = alloc_valid & alloc_ready;
    assign alloc_id      = tail_q;
    assign count         = count_q;
    assign oldest_id     = head_q;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        xcpt_d  = xcpt_q;
        dest_d  = dest_q;
        pc_d    = pc_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cid     = '0;
        if (flush_pending) begin
            valid_d = '0;
            done_d  = '0;
            xcpt_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Walk ports high to low so the lowest-index port has the final word.
            for (int p = int'(NUM_PORTS) - 1; p >= 0; p--) begin
                cid = cmpl_id[p*IDX_W +: IDX_W];
                if (cmpl_valid[p] && valid_q[cid] && !(retire && (cid == head_q))) begin
                    done_d[cid] = 1'b1;
                    data_d[cid] = cmpl_data[p*DATA_W +: DATA_W];
                    xcpt_d[cid] = xcpt_q[cid] | cmpl_xcpt[p];
                end
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                xcpt_d[head_q]  = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                xcpt_d[tail_q]  = 1'b0;
                dest_d[tail_q]  = alloc_dest;
                pc_d[tail_q]    = alloc_pc;
                tail_d          = tail_q + IDX_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(retire);
        end
    end

    // Registered retire and exception reporting.
    always_comb begin
        rf_we_d      = retire;
        rf_dest_d    = rf_dest_q;
        rf_data_d    = rf_data_q;
        rf_id_d      = rf_id_q;
        xcpt_valid_d = flush_pending;
        flush_d      = flush_pending;
        xcpt_pc_d    = xcpt_pc_q;
        xcpt_id_d    = xcpt_id_q;
        if (retire) begin
            rf_dest_d = dest_q[head_q];
            rf_data_d = data_q[head_q];
            rf_id_d   = head_q;
        end
        if (flush_pending) begin
            xcpt_pc_d = pc_q[head_q];
            xcpt_id_d = head_q;
        end
    end

    // Bypass sees only results already stored; this cycle's completions do not forward.
    always_comb begin
        byp_hit  = '0;
        byp_data = '0;
        bid      = '0;
        for (int i = 0; i < 2; i++) begin
            bid        = byp_id[i*IDX_W +: IDX_W];
            byp_hit[i] = valid_q[bid] & done_q[bid] & ~xcpt_q[bid];
            if (byp_hit[i]) begin
                byp_data[i*DATA_W +: DATA_W] = data_q[bid];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= '0;
            done_q       <= '0;
            xcpt_q       <= '0;
            dest_q       <= '{default: '0};
            pc_q         <= '{default: '0};
            data_q       <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            rf_we_q      <= 1'b0;
            rf_dest_q    <= '0;
            rf_data_q    <= '0;
            rf_id_q      <= '0;
            xcpt_valid_q <= 1'b0;
            flush_q      <= 1'b0;
            xcpt_pc_q    <= '0;
            xcpt_id_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            xcpt_q       <= xcpt_d;
            dest_q       <= dest_d;
            pc_q         <= pc_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            rf_we_q      <= rf_we_d;
            rf_dest_q    <= rf_dest_d;
            rf_data_q    <= rf_data_d;
            rf_id_q      <= rf_id_d;
            xcpt_valid_q <= xcpt_valid_d;
            flush_q      <= flush_d;
            xcpt_pc_q    <= xcpt_pc_d;
            xcpt_id_q    <= xcpt_id_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_dest    = rf_dest_q;
    assign rf_data    = rf_data_q;
    assign rf_id      = rf_id_q;
    assign xcpt_valid = xcpt_valid_q;
    assign flush      = flush_q;
    assign xcpt_pc    = xcpt_pc_q;
    assign xcpt_id    = xcpt_id_q;

endmodule

// File: tb/tb_wb_rob_param.sv
// Bench for wb_rob_param (4 entries, 3 ports): queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic with resets.
module tb_wb_rob_param;

    localparam int unsigned NE = 4;
    localparam int unsigned NP = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 5;
    localparam int unsigned PW = 32;
    localparam int unsigned IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alloc_valid;
    logic [SW-1:0]     alloc_dest;
    logic [PW-1:0]     alloc_pc;
    logic              alloc_ready;
    logic [IW-1:0]     alloc_id;
    logic [NP-1:0]     cmpl_valid;
    logic [NP*IW-1:0]  cmpl_id;
    logic [NP*DW-1:0]  cmpl_data;
    logic [NP-1:0]     cmpl_xcpt;
    logic              rf_we;
    logic [SW-1:0]     rf_dest;
    logic [DW-1:0]     rf_data;
    logic [IW-1:0]     rf_id;
    logic              xcpt_valid;
    logic [PW-1:0]     xcpt_pc;
    logic [IW-1:0]     xcpt_id;
    logic              flush;
    logic [2*IW-1:0]   byp_id;
    logic [1:0]        byp_hit;
    logic [2*DW-1:0]   byp_data;
    logic [IW:0]       count;
    logic [IW-1:0]     oldest_id;

    wb_rob_param #(.NUM_ENTRIES(NE), .NUM_PORTS(NP), .DATA_W(DW), .DEST_W(SW), .PC_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .cmpl_valid(cmpl_valid), .cmpl_id(cmpl_id), .cmpl_data(cmpl_data), .cmpl_xcpt(cmpl_xcpt),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .rf_id(rf_id),
        .xcpt_valid(xcpt_valid), .xcpt_pc(xcpt_pc), .xcpt_id(xcpt_id), .flush(flush),
        .byp_id(byp_id), .byp_hit(byp_hit), .byp_data(byp_data),
        .count(count), .oldest_id(oldest_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order queue of in-flight IDs plus per-ID records.
    int            q[$];
    bit            m_valid[NE];
    bit            m_done[NE];
    bit            m_xcpt[NE];
    logic [SW-1:0] m_dest[NE];
    logic [PW-1:0] m_pc[NE];
    logic [DW-1:0] m_data[NE];
    int            m_tail = 0;
    bit            started = 0;
    bit            e_rf_we, e_xv;
    int            e_rf_id, e_xid;
    logic [SW-1:0] e_rf_dest;
    logic [DW-1:0] e_rf_data;
    logic [PW-1:0] e_xpc;

    function automatic bit head_state(output bit rt, output bit fl);
        rt = 0;
        fl = 0;
        if (q.size() > 0) begin
            rt = m_done[q[0]] && !m_xcpt[q[0]];
            fl = m_done[q[0]] && m_xcpt[q[0]];
        end
        return rt | fl;
    endfunction

    always @(posedge clk) begin : model
        bit rt, fl, any;
        bit claimed[NE];
        int h, id, sz;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < NE; i++) begin
                m_valid[i] = 0; m_done[i] = 0; m_xcpt[i] = 0;
            end
            m_tail = 0;
            e_rf_we = 0; e_xv = 0;
            started = 1;
        end else if (started) begin
            any = head_state(rt, fl);
            h = (q.size() > 0) ? q[0] : 0;
            sz = q.size();
            e_rf_we = rt;
            e_xv = fl;
            if (rt) begin
                e_rf_id = h; e_rf_dest = m_dest[h]; e_rf_data = m_data[h];
            end
            if (fl) begin
                e_xpc = m_pc[h]; e_xid = h;
                q.delete();
                for (int i = 0; i < NE; i++) begin
                    m_valid[i] = 0; m_done[i] = 0; m_xcpt[i] = 0;
                end
                m_tail = 0;
            end else begin
                for (int i = 0; i < NE; i++) claimed[i] = 0;
                for (int p = 0; p < NP; p++) begin
                    id = int'(cmpl_id[p*IW +: IW]);
                    if (cmpl_valid[p] && m_valid[id] && !(rt && id == h) && !claimed[id]) begin
                        claimed[id] = 1;
                        m_done[id] = 1;
                        m_data[id] = cmpl_data[p*DW +: DW];
                        m_xcpt[id] = m_xcpt[id] | cmpl_xcpt[p];
                    end
                end
                if (rt) begin
                    void'(q.pop_front());
                    m_valid[h] = 0; m_done[h] = 0; m_xcpt[h] = 0;
                end
                if (alloc_valid && sz < NE) begin
                    q.push_back(m_tail);
                    m_valid[m_tail] = 1; m_done[m_tail] = 0; m_xcpt[m_tail] = 0;
                    m_dest[m_tail] = alloc_dest; m_pc[m_tail] = alloc_pc;
                    m_tail = (m_tail + 1) % NE;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        bit rt, fl, any, hit;
        int id;
        if (started) begin
            any = head_state(rt, fl);
            chk("alloc_ready", 64'(alloc_ready), 64'((q.size() < NE) && !fl));
            chk("alloc_id", 64'(alloc_id), 64'(m_tail));
            chk("count", 64'(count), 64'(q.size()));
            chk("oldest_id", 64'(oldest_id), 64'((q.size() > 0) ? q[0] : m_tail));
            for (int i = 0; i < 2; i++) begin
                id = int'(byp_id[i*IW +: IW]);
                hit = m_valid[id] && m_done[id] && !m_xcpt[id];
                chk("byp_hit", 64'(byp_hit[i]), 64'(hit));
                chk("byp_data", 64'(byp_data[i*DW +: DW]), hit ? 64'(m_data[id]) : 64'(0));
            end
            chk("rf_we", 64'(rf_we), 64'(e_rf_we));
            if (e_rf_we) begin
                chk("rf_id", 64'(rf_id), 64'(e_rf_id));
                chk("rf_dest", 64'(rf_dest), 64'(e_rf_dest));
                chk("rf_data", 64'(rf_data), 64'(e_rf_data));
            end
            chk("xcpt_valid", 64'(xcpt_valid), 64'(e_xv));
            chk("flush", 64'(flush), 64'(e_xv));
            if (e_xv) begin
                chk("xcpt_pc", 64'(xcpt_pc), 64'(e_xpc));
                chk("xcpt_id", 64'(xcpt_id), 64'(e_xid));
            end
        end
    end

    int            log_id[$];
    logic [DW-1:0] log_data[$];
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            log_id.push_back(int'(rf_id));
            log_data.push_back(rf_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_dest = '0; alloc_pc = '0;
        cmpl_valid = '0; cmpl_id = '0; cmpl_data = '0; cmpl_xcpt = '0;
        byp_id = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle();
        tick();
        tick();
        rst_n = 1;
        log_id.delete();
        log_data.delete();
    endtask

    task automatic alloc_n(input int n, input logic [PW-1:0] pc0);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1;
            alloc_dest = SW'(i + 1);
            alloc_pc = pc0 + PW'(4 * i);
            tick();
        end
        alloc_valid = 0;
    endtask

    task automatic cmpl0(input int id, input logic [DW-1:0] d);
        cmpl_valid = 3'b001;
        cmpl_id = '0;
        cmpl_id[IW-1:0] = IW'(id);
        cmpl_data = '0;
        cmpl_data[DW-1:0] = d;
        cmpl_xcpt = '0;
    endtask

    initial begin
        int order[4];
        order = '{2, 0, 3, 1};

        // Reset values
        do_reset();
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_id", 64'(alloc_id), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_fields", {rf_dest, rf_id, rf_data}, 64'd0);
        chk("rst_xcpt", {xcpt_valid, flush, xcpt_id, xcpt_pc}, 64'd0);

        // Out-of-order completion, in-order retire
        for (int i = 0; i < 4; i++) begin
            chk("seq_alloc_id", 64'(alloc_id), 64'(i));
            alloc_valid = 1; alloc_dest = SW'(i + 1); alloc_pc = PW'(32'h100 + 4 * i);
            tick();
        end
        alloc_valid = 0;
        chk("seq_full_count", 64'(count), 64'd4);
        chk("seq_full_ready", 64'(alloc_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            cmpl0(order[k], DW'(32'hA0 + order[k]));
            tick();
        end
        idle();
        repeat (8) tick();
        chk("seq_retire_n", 64'(log_id.size()), 64'd4);
        for (int k = 0; k < 4 && k < log_id.size(); k++) begin
            chk("seq_retire_id", 64'(log_id[k]), 64'(k));
            chk("seq_retire_data", 64'(log_data[k]), 64'(32'hA0 + k));
        end
        chk("seq_count_end", 64'(count), 64'd0);

        // Full buffer: held alloc accepted only after the first retire
        do_reset();
        alloc_n(4, 32'h200);
        alloc_valid = 1; alloc_dest = 5'd9;
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        cmpl0(0, 32'h5);
        tick();
        cmpl_valid = '0;
        chk("full_ready_retire_cyc", 64'(alloc_ready), 64'd0);
        tick();
        chk("full_rf_we", 64'(rf_we), 64'd1);
        chk("full_ready_after", 64'(alloc_ready), 64'd1);
        chk("full_count_after", 64'(count), 64'd3);
        chk("full_alloc_id_wrap", 64'(alloc_id), 64'd0);
        tick();
        alloc_valid = 0;
        chk("full_count_refill", 64'(count), 64'd4);
        chk("full_ready_refill", 64'(alloc_ready), 64'd0);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1; alloc_dest = SW'(i);
            chk("wrap_alloc_id", 64'(alloc_id), 64'(i % 4));
            tick();
            alloc_valid = 0;
            cmpl0(i % 4, DW'(i));
            tick();
            cmpl_valid = '0;
            tick();
            chk("wrap_rf_we", 64'(rf_we), 64'd1);
            chk("wrap_rf_id", 64'(rf_id), 64'(i % 4));
        end

        // Port collision on one ID: lowest port wins
        do_reset();
        alloc_n(2, 32'h300);
        cmpl_valid = 3'b111;
        cmpl_id = {2'd1, 2'd0, 2'd1};
        cmpl_data = {32'h22, 32'h77, 32'h11};
        tick();
        idle();
        repeat (5) tick();
        chk("coll_n", 64'(log_id.size()), 64'd2);
        if (log_data.size() == 2) begin
            chk("coll_id0_data", 64'(log_data[0]), 64'h77);
            chk("coll_id1_data", 64'(log_data[1]), 64'h11);
        end

        // Exception flush
        do_reset();
        alloc_n(3, 32'h100);
        cmpl_valid = 3'b011;
        cmpl_id = {2'd0, 2'd0, 2'd1};
        cmpl_data = {32'h0, 32'hB0, 32'hB1};
        cmpl_xcpt = 3'b001;
        tick();
        idle();
        tick();
        chk("xc_rf_we", 64'(rf_we), 64'd1);
        chk("xc_rf_id", 64'(rf_id), 64'd0);
        chk("xc_ready_pending", 64'(alloc_ready), 64'd0);
        alloc_valid = 1;
        cmpl0(2, 32'hC2);
        tick();
        alloc_valid = 0;
        chk("xc_valid", 64'(xcpt_valid), 64'd1);
        chk("xc_flush", 64'(flush), 64'd1);
        chk("xc_pc", 64'(xcpt_pc), 64'h104);
        chk("xc_id", 64'(xcpt_id), 64'd1);
        chk("xc_no_rf_we", 64'(rf_we), 64'd0);
        chk("xc_count", 64'(count), 64'd0);
        chk("xc_alloc_id", 64'(alloc_id), 64'd0);
        tick();
        idle();
        chk("xc_pulse_end", 64'({xcpt_valid, flush}), 64'd0);
        repeat (4) tick();
        chk("xc_only_id0", 64'(log_id.size()), 64'd1);
        chk("xc_count_end", 64'(count), 64'd0);

        // Bypass, then reset mid-operation
        do_reset();
        alloc_n(1, 32'h400);
        cmpl0(0, 32'h55);
        byp_id = {2'd1, 2'd0};
        chk("byp_same_cycle", 64'(byp_hit), 64'd0);
        tick();
        cmpl_valid = '0;
        chk("byp_hit", 64'(byp_hit), 64'b01);
        chk("byp_data0", 64'(byp_data[DW-1:0]), 64'h55);
        chk("byp_data1_miss", 64'(byp_data[2*DW-1:DW]), 64'd0);
        rst_n = 0;
        tick();
        chk("byp_rst_count", 64'(count), 64'd0);
        chk("byp_rst_hit", 64'(byp_hit), 64'd0);
        chk("byp_rst_rf_we", 64'(rf_we), 64'd0);
        rst_n = 1;
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            alloc_valid = ($urandom_range(0, 2) != 0);
            alloc_dest = SW'($urandom);
            alloc_pc = PW'($urandom);
            for (int p = 0; p < NP; p++) begin
                cmpl_valid[p] = ($urandom_range(0, 1) == 1);
                cmpl_id[p*IW +: IW] = IW'($urandom_range(0, 3));
                cmpl_data[p*DW +: DW] = DW'($urandom);
                cmpl_xcpt[p] = ($urandom_range(0, 24) == 0);
            end
            byp_id = (2*IW)'($urandom);
            tick();
        end
        rst_n = 1;
        idle();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_rob_param.md
WB_ROB_PARAM -- requirements
Module: wb_rob_param

Interface
REQ-001 Parameter NUM_ENTRIES, default 8, ROB depth; power of two, at least 2.
REQ-002 Parameter NUM_PORTS, default 3, completion ports (ALU, MUL, cache); at least 1.
REQ-003 Parameter DATA_W, default 32; parameter DEST_W, default 5; parameter PC_W, default 32; IDX_W = log2(NUM_ENTRIES).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low: clock  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-005 alloc_valid in 1 allocation request; alloc_dest in DEST_W RF destination; alloc_pc in PC_W instruction PC.
REQ-006 alloc_ready out 1 entry available; alloc_id out IDX_W ID assigned to the current request.
REQ-007 cmpl_valid in NUM_PORTS per-port completion; cmpl_id in NUM_PORTS*IDX_W; cmpl_data in NUM_PORTS*DATA_W; cmpl_xcpt in NUM_PORTS exception flag.
REQ-008 rf_we out 1; rf_dest out DEST_W; rf_data out DATA_W; rf_id out IDX_W (registered retire write).
REQ-009 xcpt_valid out 1; xcpt_pc out PC_W; xcpt_id out IDX_W; flush out 1 (registered pulses).
REQ-010 byp_id in 2*IDX_W source lookups; byp_hit out 2; byp_data out 2*DATA_W.
REQ-011 count out IDX_W+1 occupied entries; oldest_id out IDX_W head index.

Function
REQ-012 Storage: circular buffer; each entry holds valid, done, xcpt, dest, pc, data; head, tail and count registers.
REQ-013 alloc_ready SHALL equal (count < NUM_ENTRIES) AND NOT flush_pending; alloc_id SHALL equal tail.
REQ-014 Allocation (alloc_valid AND alloc_ready): entry[tail] set valid, done=0, xcpt=0; dest and pc captured; tail increments modulo NUM_ENTRIES.
REQ-015 alloc_ready SHALL use the current count; a retire in the same cycle SHALL NOT enable allocation into a full buffer.
REQ-016 Completion: each cmpl_valid port targeting a valid entry sets done, writes data and ORs in xcpt at the clock edge; a port targeting an invalid entry SHALL be ignored.
REQ-017 Multiple ports targeting the same ID in one cycle: the lowest port index SHALL win.
REQ-018 Retire: if entry[head] is valid, done and xcpt=0 at the start of a cycle, the entry SHALL be freed and head SHALL increment at that edge.
REQ-019 On that same edge, rf_we=1 SHALL be registered with rf_dest, rf_data and rf_id, giving one-cycle latency. At most one retire per cycle.
REQ-020 A completion to head in cycle N SHALL retire at the end of cycle N+1; rf_we SHALL be high in cycle N+2.
REQ-021 Exception: if entry[head] is valid, done and xcpt=1, then at the edge:
- xcpt_valid=1 and flush=1 SHALL be registered for one cycle, with xcpt_pc=pc and xcpt_id=head;
- rf_we SHALL stay 0;
- all valid bits SHALL be cleared and head=tail=count=0.
REQ-022 flush_pending: allocations and completions presented in the cycle an exception retires SHALL be dropped.
REQ-023 count SHALL be updated by +alloc and -retire in the same cycle, with both applied simultaneously.
REQ-024 Bypass (combinational, per source i): byp_hit[i]=1 iff entry[byp_id[i]] is valid AND done AND xcpt=0, and byp_data[i]=entry data. Same-cycle completions SHALL NOT forward. byp_data SHALL be 0 on a miss.
REQ-025 Pointers SHALL wrap from NUM_ENTRIES-1 to 0 with no lost or duplicated entry.
REQ-026 A completion for an entry that is freed in the same cycle SHALL be ignored.

Reset
REQ-027 While reset=0 at a clock edge:
- all valid, done and xcpt bits SHALL clear;
- head, tail and count SHALL reset to 0;
- rf_we, xcpt_valid and flush SHALL be 0; rf_dest, rf_data, rf_id, xcpt_pc and xcpt_id SHALL be 0.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight entries with no retire or exception output on the following cycle.
REQ-029 After reset release, alloc_ready=1 and alloc_id=0.

Verification (NUM_ENTRIES=4, NUM_PORTS=3)
REQ-030 Sequence: allocate IDs 0-3 (dest 1-4); complete in order 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1 -> rf_we retires IDs 0,1,2,3 in order with those data; count returns to 0.
REQ-031 Full buffer: 4 allocations with none complete -> alloc_ready=0 and count=4. An alloc_valid held high is not accepted until the cycle after the first retire.
REQ-032 Wrap-around: 6 allocate/complete/retire iterations -> alloc_id sequence 0,1,2,3,0,1 and rf_id matches.
REQ-033 Collision: ports 0 and 2 both complete ID 1 in one cycle with 0x11 and 0x22 -> retired data is 0x11.
REQ-034 Exception: IDs 0-2 allocated with pc 0x100/0x104/0x108; ID 1 completes with xcpt, ID 0 normally -> ID 0 retires, then xcpt_valid=1 with xcpt_pc=0x104 and flush=1. Afterwards count=0, ID 2 never retires, and alloc_id=0.
REQ-035 Bypass and reset: ID 0 done with data 0x55 -> byp_hit=1 and byp_data=0x55; asserting reset=0 that cycle -> next cycle count=0, byp_hit=0, rf_we=0.
